// File: rtl/rr_request_encoder_if.sv
// Request/grant bundle between the requesters, the round-robin encoder and the
// downstream 3-to-8 decoder consumer.
interface rr_request_encoder_if;
    logic r1;
    logic r2;
    logic r3;
    logic r4;
    logic r5;
    logic r6;
    logic r7;
    logic ack;
    logic x;
    logic y;
    logic z;
    logic valid;
    logic timeout;

    modport master (
        output r1, r2, r3, r4, r5, r6, r7, ack,
        input  x, y, z, valid, timeout
    );

    modport slave (
        input  r1, r2, r3, r4, r5, r6, r7, ack,
        output x, y, z, valid, timeout
    );
endinterface

// File: rtl/rr_request_encoder.sv
// Round-robin arbiter over seven request lines; presents the winner as a held
// 3-bit code (000 = no grant) under a valid/ack handshake with a timeout.
module rr_request_encoder #(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_request_encoder_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  last_r;
    logic [2:0]  last_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic [2:0]  code_r;
    logic [2:0]  code_s;
    logic        valid_r;
    logic        valid_s;
    logic        timeout_r;
    logic        timeout_s;
    logic [7:1]  req_s;
    logic [2:0]  winner_s;

    // Scan from the far end of the rotation back towards last+1 so the
    // nearest requester after the pointer is the one left standing.
    function automatic logic [2:0] rr_pick(input logic [7:1] req, input logic [2:0] last);
        logic [3:0] cand;
        logic [2:0] pick;
        pick = 3'd0;
        for (int off = 7; off >= 1; off--) begin
            cand = {1'b0, last} + 4'(off);
            cand = (cand > 4'd7) ? (cand - 4'd7) : cand;
            pick = req[cand[2:0]] ? cand[2:0] : pick;
        end
        return pick;
    endfunction

    assign req_s    = {bus.r7, bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1};
    assign winner_s = rr_pick(req_s, last_r);

    // Next-state and next-output logic for the IDLE/GRANT handshake.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        cnt_s     = cnt_r;
        code_s    = code_r;
        valid_s   = valid_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    code_s  = winner_s;
                    valid_s = 1'b1;
                    cnt_s   = 8'd0;
                    state_s = GRANT;
                end else begin
                    code_s  = 3'd0;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                // The stalled requester still loses its turn on a timeout.
                if (bus.ack) begin
                    last_s  = code_r;
                    code_s  = 3'd0;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    last_s    = code_r;
                    code_s    = 3'd0;
                    valid_s   = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                code_s  = 3'd0;
                valid_s = 1'b0;
                cnt_s   = 8'd0;
                last_s  = 3'd7;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            last_r    <= 3'd7;
            cnt_r     <= 8'd0;
            code_r    <= 3'd0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            cnt_r     <= cnt_s;
            code_r    <= code_s;
            valid_r   <= valid_s;
            timeout_r <= timeout_s;
        end
    end

    assign bus.x       = code_r[2];
    assign bus.y       = code_r[1];
    assign bus.z       = code_r[0];
    assign bus.valid   = valid_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_request_encoder.sv
// Randomized and directed bench for rr_request_encoder against a transaction-level
// round-robin reference model.
module tb_rr_request_encoder;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rr_request_encoder_if bus ();

    rr_request_encoder #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:1] req_v;
    logic [2:0] dut_code;
    assign req_v    = {bus.r7, bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1};
    assign dut_code = {bus.x, bus.y, bus.z};

    // Reference model: who owns the grant, how many valid cycles it has had.
    logic       m_busy;
    logic [2:0] m_code;
    int         m_last;
    int         m_age;
    logic       m_to;

    function automatic logic [2:0] ref_pick(input logic [7:1] req, input int last);
        int idx;
        for (int off = 1; off <= 7; off++) begin
            idx = ((last + off - 1) % 7) + 1;
            if (req[idx]) return 3'(idx);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_code <= 3'd0;
            m_last <= 7;
            m_age  <= 0;
            m_to   <= 1'b0;
        end else if (!m_busy) begin
            m_to <= 1'b0;
            if (req_v != 7'd0) begin
                m_code <= ref_pick(req_v, m_last);
                m_busy <= 1'b1;
                m_age  <= 1;
            end
        end else if (bus.ack) begin
            m_busy <= 1'b0;
            m_code <= 3'd0;
            m_last <= int'(m_code);
            m_to   <= 1'b0;
        end else if (m_age == TO) begin
            m_busy <= 1'b0;
            m_code <= 3'd0;
            m_last <= int'(m_code);
            m_to   <= 1'b1;
        end else begin
            m_age <= m_age + 1;
            m_to  <= 1'b0;
        end
    end

    task automatic set_req(input logic [7:1] v);
        bus.r1 = v[1];
        bus.r2 = v[2];
        bus.r3 = v[3];
        bus.r4 = v[4];
        bus.r5 = v[5];
        bus.r6 = v[6];
        bus.r7 = v[7];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        set_req(7'd0);
        bus.ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(7'd0);
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_req(7'b0000100);
        tick();
        total++;
        if (bus.valid !== 1'b1 || dut_code !== 3'b011) begin
            bad++;
            $display("FAIL reset_pregrant got v=%b code=%b want v=1 code=011", bus.valid, dut_code);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (dut_code !== 3'b000 || bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got code=%b v=%b to=%b want 000/0/0", dut_code, bus.valid, bus.timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(7'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (bus.valid !== 1'b0 || dut_code !== 3'b000 || bus.timeout !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got v=%b code=%b to=%b want 0/000/0", i, bus.valid, dut_code, bus.timeout);
            end
        end
    endtask

    task automatic test_single();
        set_req(7'b0010000);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.valid !== 1'b1 || dut_code !== 3'b101) begin
                bad++;
                $display("FAIL single_hold cyc=%0d got v=%b code=%b want v=1 code=101", i, bus.valid, dut_code);
            end
            if (i == 1) set_req(7'd0);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || dut_code !== 3'b000) begin
            bad++;
            $display("FAIL single_ack got v=%b code=%b want v=0 code=000", bus.valid, dut_code);
        end
    endtask

    task automatic test_rotation();
        int g;
        pulse_reset();
        set_req(7'b1111111);
        bus.ack = 1'b1;
        g = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (i % 2 == 0) begin
                if (bus.valid !== 1'b1 || dut_code !== 3'((g % 7) + 1)) begin
                    bad++;
                    $display("FAIL rotation grant=%0d got v=%b code=%b want v=1 code=%0d", g, bus.valid, dut_code, (g % 7) + 1);
                end
                g++;
            end else if (bus.valid !== 1'b0 || dut_code !== 3'b000) begin
                bad++;
                $display("FAIL rotation_gap cyc=%0d got v=%b code=%b want v=0 code=000", i, bus.valid, dut_code);
            end
        end
        bus.ack = 1'b0;
        set_req(7'd0);
    endtask

    task automatic test_subset();
        int g;
        pulse_reset();
        set_req(7'b0100010);
        bus.ack = 1'b1;
        g = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                total++;
                if (bus.valid !== 1'b1 || dut_code !== ((g % 2 == 0) ? 3'b010 : 3'b110)) begin
                    bad++;
                    $display("FAIL subset grant=%0d got v=%b code=%b want %s", g, bus.valid, dut_code, (g % 2 == 0) ? "010" : "110");
                end
                g++;
            end
        end
        bus.ack = 1'b0;
        set_req(7'd0);
    endtask

    task automatic test_timeout();
        pulse_reset();
        set_req(7'b0001100);
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (i < TO) begin
                if (bus.valid !== 1'b1 || dut_code !== 3'b011 || bus.timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_hold cyc=%0d got v=%b code=%b to=%b want 1/011/0", i, bus.valid, dut_code, bus.timeout);
                end
            end else if (i == TO) begin
                if (bus.valid !== 1'b0 || dut_code !== 3'b000 || bus.timeout !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_pulse got v=%b code=%b to=%b want 0/000/1", bus.valid, dut_code, bus.timeout);
                end
            end else if (bus.valid !== 1'b1 || dut_code !== 3'b100 || bus.timeout !== 1'b0) begin
                bad++;
                $display("FAIL timeout_next got v=%b code=%b to=%b want 1/100/0", bus.valid, dut_code, bus.timeout);
            end
        end
        set_req(7'd0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_collision();
        pulse_reset();
        set_req(7'b0000001);
        repeat (TO - 1) tick();
        set_req(7'd0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL collision got v=%b to=%b want v=0 to=0", bus.valid, bus.timeout);
        end
        tick();
        total++;
        if (bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL collision_late got to=%b want 0", bus.timeout);
        end
    endtask

    task automatic test_drop();
        pulse_reset();
        set_req(7'b0001000);
        tick();
        set_req(7'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.valid !== 1'b1 || dut_code !== 3'b100) begin
                bad++;
                $display("FAIL drop_hold cyc=%0d got v=%b code=%b want v=1 code=100", i, bus.valid, dut_code);
            end
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        total++;
        if (bus.valid !== 1'b0 || dut_code !== 3'b000) begin
            bad++;
            $display("FAIL drop_ack got v=%b code=%b want v=0 code=000", bus.valid, dut_code);
        end
    endtask

    task automatic test_random();
        logic [2:0] prev_code;
        logic       prev_valid;
        pulse_reset();
        prev_valid = 1'b0;
        prev_code  = 3'd0;
        for (int i = 0; i < 400; i++) begin
            set_req(7'($urandom_range(0, 127)));
            bus.ack = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
            tick();
            total++;
            if (dut_code !== m_code || bus.valid !== m_busy || bus.timeout !== m_to) begin
                bad++;
                $display("FAIL random cyc=%0d got code=%b v=%b to=%b want code=%b v=%b to=%b",
                         i, dut_code, bus.valid, bus.timeout, m_code, m_busy, m_to);
            end
            if (prev_valid && bus.valid && dut_code !== prev_code) begin
                bad++;
                $display("FAIL random_stable cyc=%0d got code=%b want held %b", i, dut_code, prev_code);
            end
            prev_valid = bus.valid;
            prev_code  = dut_code;
        end
        set_req(7'd0);
        bus.ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_subset();
        test_timeout();
        test_collision();
        test_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
